accumulator_register: RTL and testbench

//  Sequential, parametrised accumulator: sums a programmed batch of Num_Operands words into a widened register.

---
 rtl/accumulator_register.sv | 91 +++++++++
 tb/tb_accumulator_register.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_register.sv
// Batch accumulator: sums Num_Operands handshaked operands into a widened register.
// Optional ACC_SATURATION_EN: clamp to all-ones on overflow instead of wrapping.
module accumulator_register #(
    parameter int Word_Length  = 16,
    parameter int Guard_Bits   = 4,
    parameter int Num_Operands = 8,
    localparam int Acc_Length   = Word_Length + Guard_Bits,
    localparam int Count_Length = $clog2(Num_Operands + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    skip_equal,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Word_Length-1:0]  Data_Input,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [Acc_Length-1:0]   Data_Output,
    output logic [Count_Length-1:0] op_count,
    output logic                    overflow,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [Acc_Length-1:0]   acc;
    logic [Acc_Length:0]     sum_ext;
    logic                    accept;
    logic                    skip_op;
    logic                    last_op;

    assign accept  = in_valid && (state == ACCUM);
    assign skip_op = skip_equal && (Acc_Length'(Data_Input) == acc);
    assign last_op = (op_count == Count_Length'(Num_Operands - 1));
    // One extra bit captures the carry out of the accumulator width.
    assign sum_ext = {1'b0, acc} + (Acc_Length + 1)'(Data_Input);

    assign in_ready    = (state == ACCUM);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign Data_Output = acc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (accept && last_op) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: clear and a fresh start both zero the batch; clear also drops a concurrent accept.
    always_ff @(posedge clk) begin
        if (!reset || clear || (state == IDLE && start)) begin
            acc      <= '0;
            op_count <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            op_count <= op_count + Count_Length'(1);
            if (!skip_op) begin
`ifdef ACC_SATURATION_EN
                if (sum_ext[Acc_Length] || overflow) begin
                    acc <= '1;
                end else begin
                    acc <= sum_ext[Acc_Length-1:0];
                end
`else
                acc <= sum_ext[Acc_Length-1:0];
`endif
                if (sum_ext[Acc_Length]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_accumulator_register.sv
// Scoreboard bench for accumulator_register: default instance plus a narrow
// 8-bit/no-guard instance for wrap or ACC_SATURATION_EN overflow behaviour.
module tb_accumulator_register;

    localparam int W = 16;
    localparam int G = 4;
    localparam int N = 8;
    localparam int A = W + G;
    localparam int C = $clog2(N + 1);

    typedef struct packed {
        logic [A-1:0] sum;
        logic [C-1:0] cnt;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, clear, skip_equal, in_valid, out_ready;
    logic [W-1:0] data_in;
    logic         in_ready, out_valid, overflow, busy;
    logic [A-1:0] data_out;
    logic [C-1:0] op_count;

    logic         b_start, b_in_valid, b_out_ready;
    logic [7:0]   b_data_in;
    logic         b_in_ready, b_out_valid, b_overflow, b_busy;
    logic [7:0]   b_data_out;
    logic [1:0]   b_op_count;

    exp_t         sb[$];
    logic [W-1:0] ops [N];
    int           num_checks = 0;
    int           num_passed = 0;

    accumulator_register dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .skip_equal(skip_equal), .in_valid(in_valid), .in_ready(in_ready),
        .Data_Input(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .Data_Output(data_out), .op_count(op_count), .overflow(overflow),
        .busy(busy)
    );

    accumulator_register #(.Word_Length(8), .Guard_Bits(0), .Num_Operands(2)) dut_narrow (
        .clk(clk), .reset(reset), .start(b_start), .clear(clear),
        .skip_equal(skip_equal), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Data_Input(b_data_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .Data_Output(b_data_out), .op_count(b_op_count), .overflow(b_overflow),
        .busy(b_busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed === expected) begin
            num_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one full batch from ops[] and push the model's result.
    task automatic applyStimulus(input bit skip, input int gap);
        exp_t       e;
        logic [A:0] s;
        e = '0;
        skip_equal = skip;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("batch_busy", busy, 1);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                data_in  = 16'h1234;
                tick();
            end
            in_valid = 1'b1;
            data_in  = ops[i];
            if (!(skip && (A'(ops[i]) == e.sum))) begin
                s = {1'b0, e.sum} + (A + 1)'(ops[i]);
`ifdef ACC_SATURATION_EN
                e.sum = (s[A] || e.ovf) ? '1 : s[A-1:0];
`else
                e.sum = s[A-1:0];
`endif
                if (s[A]) e.ovf = 1'b1;
            end
            e.cnt = e.cnt + C'(1);
            tick();
        end
        in_valid = 1'b0;
        sb.push_back(e);
        checkOutput("latency_out_valid", out_valid, 1);
    endtask

    // Wait (bounded) for a result, compare against the scoreboard, hold it, then release.
    task automatic collectResult(input int hold, input bit with_start);
        exp_t e;
        int   waited = 0;
        out_ready = 1'b0;
        while (!out_valid && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("result_timeout", out_valid, 1);
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            checkOutput("result_sum", data_out, e.sum);
            checkOutput("result_count", op_count, e.cnt);
            checkOutput("result_overflow", overflow, e.ovf);
            checkOutput("result_in_ready", in_ready, 0);
            checkOutput("result_valid_held", out_valid, 1);
            if (h < hold) begin
                in_valid = 1'b1;
                data_in  = 16'h0007;
                tick();
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        start     = with_start;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checkOutput("back_to_idle", busy, 0);
        tick();
        checkOutput("idle_stays", busy, 0);
        checkOutput("idle_sum_held", data_out, e.sum);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; clear = 1'b0; skip_equal = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_data_in = '0;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", data_out, 0);
        checkOutput("reset_count", op_count, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_narrow_busy", b_busy, 0);
        reset = 1'b1;
        tick();

        // Back-to-back 1..8
        ops = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        applyStimulus(1'b0, 0);
        collectResult(0, 1'b0);

        // Gaps on in_valid, consumer stalls, start collides with out_ready
        applyStimulus(1'b0, 2);
        collectResult(5, 1'b1);

        // Skip-equal mode
        ops = '{16'd5, 16'd5, 16'd3, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
        applyStimulus(1'b1, 0);
        collectResult(0, 1'b0);
        skip_equal = 1'b0;

        // Large operands
        ops = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        applyStimulus(1'b0, 1);
        collectResult(1, 1'b0);

        // Clear after three accepts with in_valid still high
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; data_in = 16'(i + 10); tick();
        end
        checkOutput("pre_clear_sum", data_out, 33);
        clear = 1'b1; in_valid = 1'b1; data_in = 16'd9;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        checkOutput("clear_busy", busy, 0);
        checkOutput("clear_sum", data_out, 0);
        checkOutput("clear_count", op_count, 0);
        checkOutput("clear_in_ready", in_ready, 0);
        checkOutput("clear_out_valid", out_valid, 0);
        ops = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        applyStimulus(1'b0, 0);
        collectResult(0, 1'b0);

        // start ignored mid-batch, then a one-cycle reset pulse
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1; data_in = 16'(i); tick();
        end
        start = 1'b1; in_valid = 1'b1; data_in = 16'd3;
        tick();
        start = 1'b0; in_valid = 1'b0;
        checkOutput("start_ignored_count", op_count, 3);
        checkOutput("start_ignored_sum", data_out, 6);
        reset = 1'b0; in_valid = 1'b1; data_in = 16'd4;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_sum", data_out, 0);
        checkOutput("midreset_count", op_count, 0);
        checkOutput("midreset_in_ready", in_ready, 0);
        checkOutput("midreset_overflow", overflow, 0);
        tick();
        checkOutput("midreset_stays_idle", busy, 0);

        // Narrow instance: 200 + 100 exceeds 8 bits
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_in_valid = 1'b1; b_data_in = 8'd200; tick();
        b_data_in = 8'd100; tick();
        b_in_valid = 1'b0;
        checkOutput("narrow_out_valid", b_out_valid, 1);
`ifdef ACC_SATURATION_EN
        checkOutput("narrow_sum", b_data_out, 255);
`else
        checkOutput("narrow_sum", b_data_out, 44);
`endif
        checkOutput("narrow_overflow", b_overflow, 1);
        checkOutput("narrow_count", b_op_count, 2);
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
        checkOutput("narrow_idle", b_busy, 0);
        b_start = 1'b1; tick(); b_start = 1'b0;
        checkOutput("narrow_overflow_restart", b_overflow, 0);
        b_in_valid = 1'b1; b_data_in = 8'd7; tick();
        b_data_in = 8'd9; tick();
        b_in_valid = 1'b0;
        checkOutput("narrow_sum2", b_data_out, 16);
        checkOutput("narrow_overflow2", b_overflow, 0);
        b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
